// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-through, no-write-allocate data cache controller
// Optional load hit/miss statistics ports are enabled by defining DCACHE_STATS_EN.
module data_cache_ctrl #(
    parameter int LINES = 16,
    parameter int IDX_W = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [31:2] mem_addr_q;
    logic        mem_we_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_q;

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             cpu_hit;
    logic [IDX_W-1:0] mem_idx;
    logic [TAG_W-1:0] mem_tag;
    logic             mem_line_hit;
    logic             start_mem;
    logic             fill_ack;
    logic             write_ack;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign cpu_idx = cpu_addr_i[IDX_W+1:2];
    assign cpu_tag = cpu_addr_i[31:IDX_W+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    // Line updates use the captured request address, not the live CPU bus.
    assign mem_idx      = mem_addr_q[IDX_W+1:2];
    assign mem_tag      = mem_addr_q[31:IDX_W+2];
    assign mem_line_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

    assign start_mem = (state_q == ST_IDLE) && cpu_req_i && (cpu_we_i || !cpu_hit);
    assign fill_ack  = (state_q == ST_FILL) && mem_ack_i;
    assign write_ack = (state_q == ST_WRITE) && mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        state_d = ST_WRITE;
                    end else if (!cpu_hit) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL, ST_WRITE: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_rdata_o = 32'd0;
        mem_req_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (!cpu_we_i && cpu_hit) begin
                        cpu_rdata_o = data_q[cpu_idx];
                    end else begin
                        cpu_stall_o = 1'b1;
                    end
                end
            end
            ST_FILL, ST_WRITE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
            end
            ST_DONE: cpu_rdata_o = resp_q;
            default: ;
        endcase
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = {mem_addr_q, 2'b00};
    assign mem_wdata_o = mem_wdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            resp_q      <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (start_mem) begin
                mem_addr_q  <= cpu_addr_i[31:2];
                mem_we_q    <= cpu_we_i;
                mem_wdata_q <= cpu_we_i ? cpu_wdata_i : 32'd0;
            end else if (fill_ack || write_ack) begin
                mem_addr_q  <= '0;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= 32'd0;
            end
            if (fill_ack) begin
                valid_q[mem_idx] <= 1'b1;
                resp_q           <= mem_rdata_i;
            end
        end
    end

    // Tag/data arrays carry no reset; an aborted access must not touch them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_ack) begin
                tag_q[mem_idx]  <= mem_tag;
                data_q[mem_idx] <= mem_rdata_i;
            end else if (write_ack && mem_line_hit) begin
                data_q[mem_idx] <= mem_wdata_q;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_o  <= 16'd0;
            miss_cnt_o <= 16'd0;
        end else if ((state_q == ST_IDLE) && cpu_req_i && !cpu_we_i) begin
            if (cpu_hit) begin
                if (hit_cnt_o != 16'hFFFF) begin
                    hit_cnt_o <= hit_cnt_o + 16'd1;
                end
            end else if (miss_cnt_o != 16'hFFFF) begin
                miss_cnt_o <= miss_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule
